// File: rtl/rot_pkg.sv
// Shared constants, state encoding and position helpers
// for the perimeter rotation sequencer.
package rot_pkg;

    localparam logic [3:0] POS_MAX = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] SPEED_SLOW = 2'd0;
    localparam logic [1:0] SPEED_MED  = 2'd1;
    localparam logic [1:0] SPEED_HIGH = 2'd2;
    localparam logic [1:0] SPEED_FAST = 2'd3;

    function automatic logic [3:0] next_pos(
        input logic [3:0] p,
        input logic       ccw
    );
        if (ccw)
            return (p == 4'd0) ? POS_MAX : p - 4'd1;
        else
            return (p == POS_MAX) ? 4'd0 : p + 4'd1;
    endfunction

    function automatic logic is_wrap(
        input logic [3:0] p,
        input logic       ccw
    );
        return ccw ? (p == 4'd0) : (p == POS_MAX);
    endfunction

endpackage

// File: rtl/rot_prescaler.sv
// Step-period prescaler: counts 0..d-1 while run, holds otherwise,
// and flags the terminal count (also when d shrinks below the count).
module rot_prescaler
    import rot_pkg::*;
#(
    parameter int PW = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        clr,
    input  logic [PW:0] d,
    output logic        wrap
);

    logic [PW-1:0] cnt;
    logic [PW:0]   d_m1;

    assign d_m1 = d - {{PW{1'b0}}, 1'b1};
    assign wrap = run && ({1'b0, cnt} >= d_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (run)
            cnt <= wrap ? '0 : cnt + {{(PW-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/rot_sequencer.sv
// Rotation sequencer: walks pos around a 12-place perimeter
// at a selectable rate, with pause, manual step and lap counting.
module rot_sequencer
    import rot_pkg::*;
#(
    parameter int BASE_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       dir,
    input  logic [1:0] speed_sel,
    input  logic       step,
    input  logic       clear,
    output logic [3:0] pos,
    output logic       tick,
    output logic       lap,
    output logic [7:0] lap_count,
    output logic       running
);

    localparam int PW = $clog2(BASE_DIV * 8);
    localparam logic [PW:0] BASE = BASE_DIV[PW:0];

    state_t      state;
    state_t      state_nx;
    logic [PW:0] d;
    logic        step_q;
    logic        step_rise;
    logic        adv;
    logic        wrap;
    logic        run;
    logic        clr;

    assign d         = BASE << (2'd3 - speed_sel);
    assign step_rise = step & ~step_q;
    assign run       = (state == RUN) && enable && !clear;
    assign clr       = clear || (state == IDLE);

    rot_prescaler #(
        .PW(PW)
    ) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .clr  (clr),
        .d    (d),
        .wrap (wrap)
    );

    // A manual step outranks the enable-driven transition in that cycle.
    always_comb begin
        state_nx = state;
        adv      = 1'b0;
        if (clear) begin
            state_nx = IDLE;
        end else if (step_rise && state != RUN) begin
            adv = 1'b1;
        end else begin
            unique case (state)
                IDLE:  if (enable) state_nx = RUN;
                RUN: begin
                    if (!enable) state_nx = PAUSE;
                    else         adv      = wrap;
                end
                PAUSE: if (enable) state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step_q    <= 1'b0;
            pos       <= 4'd0;
            tick      <= 1'b0;
            lap       <= 1'b0;
            lap_count <= 8'd0;
            running   <= 1'b0;
        end else begin
            state   <= state_nx;
            step_q  <= step;
            running <= (state_nx == RUN);
            tick    <= adv;
            lap     <= adv && is_wrap(pos, dir);
            if (clear) begin
                pos       <= 4'd0;
                lap_count <= 8'd0;
            end else if (adv) begin
                pos <= next_pos(pos, dir);
                if (is_wrap(pos, dir))
                    lap_count <= lap_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rot_sequencer.sv
// Scoreboard bench for rot_sequencer with BASE_DIV=4:
// directed scenarios followed by randomized input traffic.
module tb_rot_sequencer;

    localparam int BASE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] speed_sel = 2'd3;
    logic       step = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] pos;
    logic       tick;
    logic       lap;
    logic [7:0] lap_count;
    logic       running;

    rot_sequencer #(.BASE_DIV(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .dir      (dir),
        .speed_sel(speed_sel),
        .step     (step),
        .clear    (clear),
        .pos      (pos),
        .tick     (tick),
        .lap      (lap),
        .lap_count(lap_count),
        .running  (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int p;
        int l;
        int lc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    // Reference model: mode 0 idle, 1 run, 2 pause.
    int m_mode = 0;
    int m_elapsed = 0;
    int m_pos = 0;
    int m_laps = 0;
    int m_prev_step = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)",
                     nm, act, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_elapsed = 0;
        m_pos = 0;
        m_laps = 0;
        m_prev_step = 0;
    endtask

    task automatic model_advance();
        exp_t e;
        int wrapped;
        wrapped = (dir == 1'b0 && m_pos == 11) || (dir == 1'b1 && m_pos == 0);
        m_pos = dir ? (m_pos + 11) % 12 : (m_pos + 1) % 12;
        m_laps = (m_laps + wrapped) % 256;
        e.cyc = cycle + 1;
        e.p = m_pos;
        e.l = wrapped;
        e.lc = m_laps;
        q.push_back(e);
    endtask

    task automatic model_edge();
        int d;
        int rise;
        d = BASE << (3 - int'(speed_sel));
        rise = (step == 1'b1) && (m_prev_step == 0);
        m_prev_step = int'(step);
        if (clear) begin
            m_mode = 0;
            m_pos = 0;
            m_laps = 0;
            m_elapsed = 0;
        end else if (rise && m_mode != 1) begin
            model_advance();
        end else if (m_mode == 0) begin
            if (enable) begin
                m_mode = 1;
                m_elapsed = 0;
            end
        end else if (m_mode == 1) begin
            if (!enable) begin
                m_mode = 2;
            end else begin
                m_elapsed++;
                if (m_elapsed >= d) begin
                    m_elapsed = 0;
                    model_advance();
                end
            end
        end else if (enable) begin
            m_mode = 1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        cycle++;
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cycle) begin
                chk("missing_tick", 0, 1);
                void'(q.pop_front());
            end
            if (tick) begin
                if (q.size() == 0) begin
                    chk("unexpected_tick", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("tick_cycle", cycle, e.cyc);
                    chk("tick_pos", int'(pos), e.p);
                    chk("tick_lap", int'(lap), e.l);
                    chk("tick_lap_count", int'(lap_count), e.lc);
                end
            end else begin
                chk("lap_without_tick", int'(lap), 0);
            end
            chk("running", int'(running), int'(m_mode == 1));
            chk("pos", int'(pos), m_pos);
            chk("lap_count", int'(lap_count), m_laps);
        end
    end

    task automatic wait_elapsed(input int target, input string nm);
        int n;
        n = 0;
        while (!(m_mode == 1 && m_elapsed == target) && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_pos(input int target, input string nm);
        int n;
        n = 0;
        while (m_pos != target && n < 500) begin
            cyc();
            n++;
        end
        if (n >= 500) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_pos"}, int'(pos), 0);
        chk({nm, "_tick"}, int'(tick), 0);
        chk({nm, "_lap"}, int'(lap), 0);
        chk({nm, "_lap_count"}, int'(lap_count), 0);
        chk({nm, "_running"}, int'(running), 0);
    endtask

    initial begin
        model_reset();
        #2;
        check_all_zero("reset");
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        // Clockwise full lap at D=4.
        enable = 1'b1;
        dir = 1'b0;
        speed_sel = 2'd3;
        cycles(52);

        // Counter-clockwise from home.
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        dir = 1'b1;
        cycles(10);

        // Pause at prescaler 2 for 10 cycles.
        wait_elapsed(2, "pause_wait");
        enable = 1'b0;
        cycles(10);
        enable = 1'b1;
        cycles(6);

        // Manual steps from IDLE, then one ignored while running.
        clear = 1'b1;
        enable = 1'b0;
        dir = 1'b0;
        cyc();
        clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            cycles(5);
            step = 1'b0;
            cycles(5);
        end
        chk("steps_pos", int'(pos), 3);
        chk("steps_running", int'(running), 0);
        enable = 1'b1;
        cycles(2);
        step = 1'b1;
        cycles(5);
        step = 1'b0;
        cycles(3);

        // Speed change at prescaler 20.
        speed_sel = 2'd0;
        wait_elapsed(20, "speed_wait");
        speed_sel = 2'd3;
        cycles(12);

        // Clear at pos 7 while enabled.
        wait_pos(7, "clear_wait");
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clear_pos", int'(pos), 0);
        chk("clear_running", int'(running), 0);
        cyc();
        chk("clear_resume", int'(running), 1);
        cycles(6);

        // Asynchronous reset mid-period at pos 5.
        wait_pos(5, "reset_wait");
        cyc();
        #5;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        chk("reset_queue_empty", q.size(), 0);
        model_reset();
        q.delete();
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        chk("reset_idle_pos", int'(pos), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) dir = ~dir;
            if ($urandom_range(0, 59) == 0) speed_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) step = ~step;
            clear = ($urandom_range(0, 199) == 0);
            cyc();
        end
        clear = 1'b0;
        enable = 1'b0;
        cycles(3);
        chk("final_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rot_sequencer.md
ROT_SEQUENCER -- requirements
Module: rot_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter BASE_DIV, default 12_500_000: clk cycles per position step at the fastest speed (4 Hz at 50 MHz).
REQ-003 clk  in  1  system clock; all other inputs are synchronous to it.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 enable  in  1  level; 1 = run, 0 = pause.
REQ-006 dir  in  1  0 = clockwise (pos increments), 1 = counter-clockwise (pos decrements).
REQ-007 speed_sel  in  2  step period D = BASE_DIV << (3 - speed_sel); 3 is the fastest.
REQ-008 step  in  1  level; a rising edge requests a single manual step.
REQ-009 clear  in  1  synchronous clear to the home position.
REQ-010 pos  out  4  current perimeter position, 0..11, for the 4-digit rotation decoder.
REQ-011 tick  out  1  one-cycle pulse in the cycle pos takes a new value.
REQ-012 lap  out  1  one-cycle pulse on a wrap (11->0 or 0->11).
REQ-013 lap_count  out  8  number of completed laps, modulo 256.
REQ-014 running  out  1  high while the state is RUN.

Function
REQ-015 The FSM SHALL have three states, IDLE, RUN and PAUSE, and SHALL enter IDLE on reset.
REQ-016 The FSM SHALL take these transitions: IDLE->RUN on enable=1; RUN->PAUSE on enable=0; PAUSE->RUN on enable=1; any state->IDLE on clear=1.
REQ-017 Event priority SHALL be clear > step > enable/prescaler; clear and enable both high SHALL give IDLE, then RUN on the next cycle if clear drops.
REQ-018 clear SHALL set pos=0, lap_count=0 and prescaler=0, and SHALL suppress tick and lap in that cycle.
REQ-019 On entry from IDLE into RUN, the prescaler SHALL start at 0.
REQ-020 In RUN, the prescaler SHALL count 0..D-1; at D-1 it SHALL return to 0 and pos SHALL advance one place in direction dir, with tick=1 in the same cycle.
REQ-021 The first advance SHALL occur D cycles after RUN is entered.
REQ-022 PAUSE SHALL hold pos and the prescaler value; on resume, counting SHALL continue from the held value.
REQ-023 A step rising edge SHALL be detected as step & ~step_q.
REQ-024 In IDLE or PAUSE, a step rising edge SHALL advance pos one place on that same clock edge and assert tick; the prescaler SHALL be unchanged.
REQ-025 In RUN, a step edge SHALL be ignored.
REQ-026 A held step level SHALL produce exactly one advance.
REQ-027 Wrap: clockwise 11->0 and counter-clockwise 0->11 SHALL each assert lap together with tick and increment lap_count; lap_count SHALL wrap 255->0.
REQ-028 pos SHALL never leave the range 0..11.
REQ-029 A dir change SHALL apply at the next advance, with no extra tick.
REQ-030 A speed_sel change SHALL apply immediately. If prescaler >= new D-1, the block SHALL advance on the next clock edge and reset the prescaler to 0.
REQ-031 The prescaler width SHALL be $clog2(BASE_DIV*8), so no overflow is possible.
REQ-032 tick, lap, pos, lap_count and running SHALL be registered outputs.

Reset
REQ-033 rst_n=0 SHALL immediately set pos=0, tick=0, lap=0, lap_count=0, running=0, prescaler=0, step_q=0 and state=IDLE, regardless of the clock.
REQ-034 A reset asserted mid-run SHALL abort the current step period; after release the block SHALL wait in IDLE until enable=1.

Structure
REQ-035 Package rot_pkg SHALL hold POS_MAX=11, the state enum (IDLE, RUN, PAUSE) and the speed_sel encodings.
REQ-036 The prescaler SHALL be one sub-module, rot_prescaler: inputs run, clr and D; output wrap pulse.
REQ-037 The rotation decoder SHALL be instantiated by the top level, not inside rot_sequencer.

Verification (BASE_DIV=4)
REQ-038 Reset, enable=1, dir=0, speed_sel=3 (D=4) -> pos=1 four cycles after RUN entry; pos steps 0..11 then 0 at cycle 48 with lap=1 and lap_count=1.
REQ-039 dir=1 from pos=0, D=4 -> pos=11 at cycle 4 with lap=1 and lap_count=1; then pos=10 at cycle 8.
REQ-040 enable low at prescaler=2 for 10 cycles, then high -> pos frozen during the pause; next tick exactly 2 cycles after resume.
REQ-041 IDLE, three step pulses each held 5 cycles -> pos=3 with exactly 3 ticks; a step pulse while in RUN -> no extra tick.
REQ-042 speed_sel 0->3 at prescaler=20 -> tick on the next cycle, prescaler=0, then period 4; clear at pos=7 with enable=1 -> pos=0, lap_count=0, IDLE for one cycle, then RUN.
REQ-043 rst_n low mid-period at pos=5 -> all outputs 0 before the next clock edge.
